// File: rtl/win_div_16_if.sv
// Handshake and result bundle for the win_div_16 sequential divider.
// master drives the request side, slave is the divider.
interface win_div_16_if #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
);
  logic             start;
  logic [DVD_W-1:0] div_a;     // two's complement dividend
  logic [DVS_W-1:0] div_b;     // sign-magnitude divisor
  logic             busy;
  logic             done;
  logic [DVS_W-1:0] quo;       // sign-magnitude, saturated
  logic [DVS_W-1:0] rem;       // sign-magnitude
  logic             ovf;
  logic             div_zero;

  modport master (
    output start, div_a, div_b,
    input  busy, done, quo, rem, ovf, div_zero
  );

  modport slave (
    input  start, div_a, div_b,
    output busy, done, quo, rem, ovf, div_zero
  );
endinterface

// File: rtl/win_div_16.sv
// Sequential signed divider: 16-bit two's-complement dividend by an 8-bit
// sign-magnitude divisor. Restoring radix-2, one quotient bit per cycle.
// The quotient and remainder come back in 8-bit sign-magnitude form.
// Flow: IDLE -> LOAD -> ITER x16 -> FIX -> DONE -> IDLE, which gives 19 cycles
// from start to done.
module win_div_16 #(
  parameter int DVD_W  = 16,
  parameter int DVS_W  = 8,
  parameter int ITER_N = 16
) (
  input logic         clk,
  input logic         rst_n,
  win_div_16_if.slave bus
);

  localparam int CNT_W = $clog2(ITER_N);
  localparam int MAG_W = DVS_W - 1;   // sign-magnitude magnitude width

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Captured request.
  logic [DVD_W-1:0] a_cap;
  logic [DVS_W-1:0] b_cap;

  // Working registers.
  logic [DVD_W-1:0] dvd_sh;    // |dividend|, shifted out MSB first
  logic [MAG_W-1:0] mag_b;
  logic             sign_q;
  logic             sign_r;
  logic [MAG_W-1:0] prem;      // partial remainder
  logic [DVD_W-1:0] q_acc;     // full-width quotient magnitude
  logic [CNT_W-1:0] cnt;

  // Iteration datapath.
  logic [MAG_W:0]   trial;
  logic             take;
  logic [MAG_W-1:0] diff;
  logic             last_iter;

  // Result shaping.
  logic             q_big;
  logic [MAG_W-1:0] q_mag;
  logic             b_zero;
  logic [DVD_W-1:0] a_abs;

  // The partial remainder is held to MAG_W bits. For a nonzero divisor it is
  // always less than mag_b, which is at most 127. After the shift, the trial
  // value is one bit wider. That is the 9-bit shift-and-compare restricted to
  // the bits that can be nonzero. A successful subtract always leaves a
  // result below mag_b, so a MAG_W-bit modular difference is exact. When the
  // divisor is zero the working value is meaningless, because FIX overrides
  // it.
  assign trial     = {prem, dvd_sh[DVD_W-1]};
  assign take      = (trial >= {1'b0, mag_b});
  assign diff      = trial[MAG_W-1:0] - mag_b;
  assign last_iter = (cnt == CNT_W'(ITER_N - 1));

  // Any quotient bit at or above 2^MAG_W means the magnitude does not fit.
  assign q_big  = |q_acc[DVD_W-1:MAG_W];
  assign q_mag  = q_big ? {MAG_W{1'b1}} : q_acc[MAG_W-1:0];
  assign b_zero = (mag_b == '0);

  // Absolute value of the dividend. 0x8000 maps to 0x8000, which is 32768
  // when read as unsigned.
  assign a_abs = a_cap[DVD_W-1] ? (~a_cap + DVD_W'(1)) : a_cap;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. start is honoured only in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_ITER;
      S_ITER:  if (last_iter) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs, decoded from the state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_LOAD, S_ITER, S_FIX: bus.busy = 1'b1;
      S_DONE:                bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture the request, set up the magnitudes and signs, iterate,
  // then register the finished results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_cap        <= '0;
      b_cap        <= '0;
      dvd_sh       <= '0;
      mag_b        <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      prem         <= '0;
      q_acc        <= '0;
      cnt          <= '0;
      bus.quo      <= '0;
      bus.rem      <= '0;
      bus.ovf      <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_cap <= bus.div_a;
            b_cap <= bus.div_b;
          end
        end
        S_LOAD: begin
          dvd_sh <= a_abs;
          mag_b  <= b_cap[MAG_W-1:0];
          sign_q <= a_cap[DVD_W-1] ^ b_cap[DVS_W-1];
          sign_r <= a_cap[DVD_W-1];
          prem   <= '0;
          q_acc  <= '0;
          cnt    <= '0;
        end
        S_ITER: begin
          dvd_sh <= {dvd_sh[DVD_W-2:0], 1'b0};
          q_acc  <= {q_acc[DVD_W-2:0], take};
          prem   <= take ? diff : trial[MAG_W-1:0];
          cnt    <= cnt + CNT_W'(1);   // wraps to 0 on the last pass
        end
        S_FIX: begin
          if (b_zero) begin
            bus.quo      <= {sign_q, {MAG_W{1'b1}}};
            bus.rem      <= '0;
            bus.ovf      <= 1'b0;
            bus.div_zero <= 1'b1;
          end else begin
            // Zero magnitudes never carry a sign bit.
            bus.quo      <= {sign_q & (|q_mag), q_mag};
            bus.rem      <= {sign_r & (|prem), prem};
            bus.ovf      <= q_big;
            bus.div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_win_div_16.sv
// Self-checking bench for win_div_16. It runs directed cases, random
// operations against an arithmetic reference, the handshake cases and a
// reset abort.
module tb_win_div_16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  win_div_16_if bus();

  win_div_16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: signed division with truncation toward zero, using plain
  // integer arithmetic, then mapped to sign-magnitude.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [7:0] eq, output logic [7:0] er,
                                output logic eo, output logic ez);
    int ai, ma, mb, q, r;
    logic sq;
    ai = int'($signed(a));
    ma = (ai < 0) ? -ai : ai;
    mb = int'(b[6:0]);
    sq = a[15] ^ b[7];
    eq = 8'h00; er = 8'h00; eo = 1'b0; ez = 1'b0;
    if (mb == 0) begin
      eq = {sq, 7'h7F};
      ez = 1'b1;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (q > 127) begin
        eq = {sq, 7'h7F};
        eo = 1'b1;
      end else if (q != 0) begin
        eq = {sq, 7'(q)};
      end
      if (r != 0) er = {a[15], 7'(r)};
    end
  endfunction

  // Issues one start and waits for done (bounded).
  // lat is the cycle index in which done was seen, where cycle 0 is the
  // start-sampling cycle. busy_err counts the cycles before done in which
  // busy was low. done_nx is done one cycle later.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output int lat, output int busy_err,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic o, output logic z, output logic done_nx);
    @(negedge clk);
    bus.start = 1'b1; bus.div_a = a; bus.div_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.div_a = 16'($urandom);
    bus.div_b = 8'($urandom);
    lat = 1; busy_err = 0;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_err++;
      @(posedge clk); #1;
      lat++;
    end
    q = bus.quo; r = bus.rem; o = bus.ovf; z = bus.div_zero;
    if (bus.busy) busy_err++;
    @(posedge clk); #1;
    done_nx = bus.done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b1;               // reset must win over start
    bus.div_a = 16'h1234; bus.div_b = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.quo !== 8'h00) begin bad++; $display("FAIL reset_quo: got %h want 00", bus.quo); end
    total++; if (bus.rem !== 8'h00) begin bad++; $display("FAIL reset_rem: got %h want 00", bus.rem); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", bus.div_zero); end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_directed;
    logic [15:0] ta [6] = '{16'h03E8, 16'hFF9C, 16'h8000, 16'h03E8, 16'h0123, 16'hFFFD};
    logic [7:0]  tb [6] = '{8'h0A,    8'h87,    8'h01,    8'h87,    8'h80,    8'h05};
    logic [7:0]  tq [6] = '{8'h64,    8'h0E,    8'hFF,    8'hFF,    8'hFF,    8'h00};
    logic [7:0]  tr [6] = '{8'h00,    8'h82,    8'h00,    8'h06,    8'h00,    8'h83};
    logic        to [6] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    logic        tz [6] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
    int lat, berr;
    logic [7:0] q, r;
    logic o, z, dn;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], lat, berr, q, r, o, z, dn);
      total++; if (lat !== 19) begin bad++; $display("FAIL dir%0d_latency: got %0d want 19", i, lat); end
      total++; if (berr !== 0) begin bad++; $display("FAIL dir%0d_busy: %0d bad busy cycles want 0", i, berr); end
      total++; if (dn !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, dn); end
      total++; if ({q, r, o, z} !== {tq[i], tr[i], to[i], tz[i]})
        begin bad++; $display("FAIL dir%0d_result: got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                              i, q, r, o, z, tq[i], tr[i], to[i], tz[i]); end
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [7:0] b, eq, er, q, r;
    logic eo, ez, o, z, dn;
    int lat, berr;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 16'h8000;
        1:       a = 16'h7FFF;
        2:       a = 16'($urandom_range(0, 400)) - 16'd200;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       b = $urandom_range(0, 1) ? 8'h80 : 8'h00;
        1:       b = $urandom_range(0, 1) ? 8'h81 : 8'h01;
        2:       b = $urandom_range(0, 1) ? 8'hFF : 8'h7F;
        default: b = 8'($urandom);
      endcase
      model(a, b, eq, er, eo, ez);
      run_op(a, b, lat, berr, q, r, o, z, dn);
      total++; if (lat !== 19 || berr !== 0 || dn !== 1'b0)
        begin bad++; $display("FAIL rnd%0d_timing: lat=%0d busyerr=%0d done_nx=%b want 19/0/0", i, lat, berr, dn); end
      total++; if ({q, r, o, z} !== {eq, er, eo, ez})
        begin bad++; $display("FAIL rnd%0d_result a=%h b=%h: got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                              i, a, b, q, r, o, z, eq, er, eo, ez); end
    end
  endtask

  task automatic test_ignore_start;
    logic [15:0] a;
    logic [7:0] b, eq, er, gq, gr;
    logic eo, ez, go, gz;
    int n, dones, first;
    a = 16'($urandom); b = 8'($urandom_range(1, 127)) | (8'($urandom_range(0, 1)) << 7);
    model(a, b, eq, er, eo, ez);
    gq = 8'h00; gr = 8'h00; go = 1'b0; gz = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.div_a = a; bus.div_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1; dones = 0; first = 0;
    while (n < 45) begin
      if (n == 5 || n == 18) begin
        bus.start = 1'b1; bus.div_a = 16'($urandom); bus.div_b = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (first == 0) begin
          first = n; gq = bus.quo; gr = bus.rem; go = bus.ovf; gz = bus.div_zero;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    total++; if (first !== 19) begin bad++; $display("FAIL ignore_latency: got %0d want 19", first); end
    total++; if ({gq, gr, go, gz} !== {eq, er, eo, ez})
      begin bad++; $display("FAIL ignore_result: got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                            gq, gr, go, gz, eq, er, eo, ez); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea [3];
    logic [7:0] eb [3], eq [3], er [3];
    logic eo [3], ez [3];
    int n, k;
    for (int i = 0; i < 3; i++) begin
      ea[i] = 16'($urandom); eb[i] = 8'($urandom);
      model(ea[i], eb[i], eq[i], er[i], eo[i], ez[i]);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.div_a = ea[0]; bus.div_b = eb[0];
    @(posedge clk); #1;
    n = 1; k = 0;
    while (n < 80 && k < 3) begin
      if (bus.done) begin
        total++; if (n !== 19 + 20 * k) begin bad++; $display("FAIL b2b%0d_cycle: got %0d want %0d", k, n, 19 + 20 * k); end
        total++; if ({bus.quo, bus.rem, bus.ovf, bus.div_zero} !== {eq[k], er[k], eo[k], ez[k]})
          begin bad++; $display("FAIL b2b%0d_result: got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                                k, bus.quo, bus.rem, bus.ovf, bus.div_zero, eq[k], er[k], eo[k], ez[k]); end
        k++;
        if (k < 3) begin bus.div_a = ea[k]; bus.div_b = eb[k]; end
        else bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    total++; if (k !== 3) begin bad++; $display("FAIL b2b_timeout: got %0d dones want 3", k); end
  endtask

  task automatic test_reset_abort;
    int lat, berr, dones;
    logic [7:0] q, r, eq, er;
    logic o, z, dn, eo, ez;
    logic [15:0] a;
    logic [7:0] b;
    // Leave nonzero results on the outputs so the clear is visible.
    run_op(16'h03E8, 8'h87, lat, berr, q, r, o, z, dn);
    @(negedge clk);
    bus.start = 1'b1; bus.div_a = 16'h0123; bus.div_b = 8'h80;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);     // now in cycle 11, the 10th ITER cycle
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", bus.done); end
    total++; if (bus.quo !== 8'h00) begin bad++; $display("FAIL abort_quo: got %h want 00", bus.quo); end
    total++; if (bus.rem !== 8'h00) begin bad++; $display("FAIL abort_rem: got %h want 00", bus.rem); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL abort_ovf: got %b want 0", bus.ovf); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL abort_dz: got %b want 0", bus.div_zero); end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done || bus.busy) dones++;
      @(posedge clk); #1;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
    a = 16'($urandom); b = 8'($urandom);
    model(a, b, eq, er, eo, ez);
    run_op(a, b, lat, berr, q, r, o, z, dn);
    total++; if (lat !== 19) begin bad++; $display("FAIL abort_restart_latency: got %0d want 19", lat); end
    total++; if ({q, r, o, z} !== {eq, er, eo, ez})
      begin bad++; $display("FAIL abort_restart_result: got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                            q, r, o, z, eq, er, eo, ez); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.div_a = '0;
    bus.div_b = '0;
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/win_div_16.md
Name: win_div_16

Overview:
- Sequential signed divider; the inverse operation of win_mul_8.
- Takes a 16-bit two's-complement dividend (the format win_mul_8 produces on mul_out) and an 8-bit sign-magnitude divisor (the format win_mul_8 consumes).
- Returns an 8-bit sign-magnitude quotient and remainder.
- Used to requantize accumulated products back to the 8-bit operand format (e.g. averaging/scaling after the Winograd output transform). Restoring radix-2 division, one quotient bit per cycle, start/done handshake.

Parameters:
- DVD_W, 16, dividend width, two's complement.
- DVS_W, 8, divisor/quotient/remainder width, sign-magnitude (MSB = sign).
- ITER_N, 16, iteration count; must equal DVD_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- div_a  in  16  dividend, two's complement; captured on the accepted start.
- div_b  in  8  divisor, sign-magnitude; captured on the accepted start.
- busy  out  1  high in LOAD, ITER and FIX.
- done  out  1  one-cycle pulse; results valid.
- quo  out  8  quotient, sign-magnitude, saturated.
- rem  out  8  remainder, sign-magnitude.
- ovf  out  1  quotient magnitude exceeded 127 and was saturated.
- div_zero  out  1  divisor magnitude was 0.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - busy, done, quo, rem, ovf and div_zero all go to 0.
  - Internal registers and the iteration counter are cleared.
  - Reset mid-operation aborts; no done is produced for the aborted request.
- States and transitions:
  - IDLE -> LOAD when start=1. div_a and div_b are registered at this edge.
  - LOAD, 1 cycle:
    - mag_a = |div_a| as 16-bit unsigned; 0x8000 gives 32768.
    - mag_b = div_b[6:0].
    - sign_q = div_a[15] ^ div_b[7]; sign_r = div_a[15].
    - Partial remainder and counter are cleared. Next state is ITER.
  - ITER, 16 cycles, MSB first. Each cycle:
    - Shift the partial remainder (9 bits) left, bringing in the next mag_a bit.
    - If the partial remainder >= mag_b, subtract and set the quotient bit to 1; otherwise the quotient bit is 0.
    - The counter wraps 15 -> 0 and the FSM exits to FIX.
  - FIX, 1 cycle: apply sign, saturation and zero rules; register the outputs. Next state is DONE.
  - DONE, 1 cycle: done=1, busy=0. Next state is IDLE.
- Latency and handshake:
  - Fixed 19 cycles: done is high in the 19th cycle after the cycle in which start was sampled high.
  - The minimum start-to-start interval is 20 cycles; start held high continuously gives one operation every 20 cycles.
  - start is ignored in LOAD, ITER, FIX and DONE; it is not queued.
  - div_a and div_b may change after capture without effect.
- Output hold: quo, rem, ovf and div_zero hold their values until the next FIX or reset.
- Rounding: truncation toward zero; |rem| < |divisor|.
- Quotient magnitude q (16-bit internal):
  - If q > 127: quo magnitude = 127, ovf = 1.
  - Otherwise quo magnitude = q[6:0], ovf = 0.
  - quo[7] = sign_q, except 0 when the magnitude is 0 (no negative zero).
- Remainder:
  - The true remainder is kept even when ovf=1.
  - rem[7] = sign_r, except 0 when the remainder is 0.
- Divide by zero:
  - Applies to mag_b = 0, which includes div_b = 0x00 and 0x80.
  - Latency is unchanged; the iterations still run.
  - FIX forces quo = {sign_q, 7'h7F}, rem = 0, div_zero = 1, ovf = 0.
- Simultaneous events: rst_n low wins over start in the same cycle.

Test Plan:
- 1000 / +10: div_a=0x03E8, div_b=0x0A, start for 1 cycle -> 19 cycles later done=1 for one cycle; quo=0x64, rem=0x00, ovf=0, div_zero=0; busy high for cycles 1-18.
- -100 / -7: div_a=0xFF9C, div_b=0x87 -> quo=0x0E (+14), rem=0x82 (-2), ovf=0.
- Overflow: div_a=0x8000, div_b=0x01 -> quo=0xFF (-127), rem=0x00, ovf=1. Then div_a=0x03E8, div_b=0x87 -> quo=0xFF, rem=0x06, ovf=1.
- Divide by zero: div_a=0x0123, div_b=0x80 -> quo=0xFF (sign_q = 0^1), rem=0x00, div_zero=1, ovf=0, done still at cycle 19.
- Negative zero: div_a=0xFFFD (-3), div_b=0x05 -> quo=0x00 (not 0x80), rem=0x83.
- Handshake and reset:
  - start pulsed again at cycles 5 and 18 -> ignored; exactly one done.
  - start held high -> done every 20 cycles.
  - rst_n low at cycle 10 of ITER -> next cycle all outputs 0, state IDLE, no done; a new start after release completes normally.
